// File: rtl/insn_fetch.sv
// Prefetching instruction-fetch unit. Streams sequential words from a
// variable-latency memory port into a small queue and presents the word that
// matches the core's current address. A non-sequential core address flushes
// the queue and redirects fetching; an in-flight request that became stale is
// drained (its data dropped) before the new stream starts.

`ifndef RESETVECTOR
`define RESETVECTOR 32'h0000_0000
`endif

module insn_fetch #(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = `RESETVECTOR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] core_addr,
  output logic [31:0] core_data,
  output logic        core_ready,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] w_rd_ptr_next;
  logic [PW-1:0] w_wr_ptr_next;

  logic [31:0]   r_fa;
  logic [31:0]   w_fa_next;
  logic [31:0]   r_mem_addr;
  logic [31:0]   w_mem_addr_next;

  logic [31:0]   r_q_addr [DEPTH];
  logic [31:0]   r_q_data [DEPTH];

  logic [AW-1:0] w_rd_idx;
  logic [AW-1:0] w_wr_idx;
  logic          w_empty;
  logic          w_full;
  logic [PW-1:0] w_count;
  logic [PW-1:0] w_count_after;
  logic          w_space_after;

  logic [31:0]   w_head_addr;
  logic [31:0]   w_head_data;
  logic [31:0]   w_exp_addr;
  logic          w_hit;
  logic          w_pop;
  logic          w_redirect;
  logic          w_ack;
  logic          w_push;

  // Queue bookkeeping: extra pointer MSB distinguishes full from empty.
  assign w_rd_idx    = r_rd_ptr[AW-1:0];
  assign w_wr_idx    = r_wr_ptr[AW-1:0];
  assign w_empty     = (r_rd_ptr == r_wr_ptr);
  assign w_full      = (r_rd_ptr[PW-1] != r_wr_ptr[PW-1]) &&
                       (r_rd_ptr[AW-1:0] == r_wr_ptr[AW-1:0]);
  assign w_count     = r_wr_ptr - r_rd_ptr;
  assign w_head_addr = r_q_addr[w_rd_idx];
  assign w_head_data = r_q_data[w_rd_idx];

  // Classification of the core address against the expected address.
  // When empty, the expected address is the next fetch address so a core
  // waiting on the stream being fetched is not mistaken for a branch.
  assign w_exp_addr  = w_empty ? r_fa : w_head_addr;
  assign w_hit       = !w_empty && (core_addr == w_exp_addr);
  assign w_pop       = !w_empty && (core_addr == (w_exp_addr + 32'd1));
  assign w_redirect  = (core_addr != w_exp_addr) && !w_pop;

  // Acks are only meaningful while a request is actually on the port.
  // Data of a stale request (draining, or killed by a same-cycle redirect)
  // never enters the queue.
  assign w_ack       = mem_ack && (r_state != S_IDLE);
  assign w_push      = w_ack && (r_state == S_REQ) && !w_redirect;

  // Occupancy after this edge decides whether a back-to-back request fits.
  assign w_count_after = w_count + PW'(1) - {{(PW-1){1'b0}}, w_pop};
  assign w_space_after = (w_count_after < DEPTH_P);

  assign core_ready  = w_hit;
  assign core_data   = w_empty ? 32'd0 : w_head_data;
  assign mem_req     = (r_state != S_IDLE);
  assign mem_addr    = r_mem_addr;

  // Next-state, pointer and fetch-address logic.
  always_comb begin
    w_state_next    = r_state;
    w_rd_ptr_next   = r_rd_ptr;
    w_wr_ptr_next   = r_wr_ptr;
    w_fa_next       = r_fa;
    w_mem_addr_next = r_mem_addr;

    // A redirect flushes everything; otherwise pop and push are independent.
    if (w_redirect) begin
      w_rd_ptr_next = r_wr_ptr;
      w_fa_next     = core_addr;
    end else begin
      if (w_pop) begin
        w_rd_ptr_next = r_rd_ptr + PW'(1);
      end
      if (w_push) begin
        w_wr_ptr_next = r_wr_ptr + PW'(1);
        w_fa_next     = r_fa + 32'd1;
      end
    end

    // Every new request is issued at the fetch address as it will be after
    // this edge, so redirects and pushes are folded in automatically.
    case (r_state)
      S_IDLE: begin
        if (w_redirect || !w_full) begin
          w_state_next    = S_REQ;
          w_mem_addr_next = w_fa_next;
        end
      end
      S_REQ: begin
        if (w_ack) begin
          if (w_redirect || w_space_after) begin
            w_state_next    = S_REQ;
            w_mem_addr_next = w_fa_next;
          end else begin
            w_state_next = S_IDLE;
          end
        end else if (w_redirect) begin
          // The memory owns the request now; keep it on the port untouched.
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_ack) begin
          w_state_next    = S_REQ;
          w_mem_addr_next = w_fa_next;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Control state with asynchronous reset; abandons any request instantly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_fa       <= RESET_ADDR;
      r_mem_addr <= RESET_ADDR;
    end else begin
      r_state    <= w_state_next;
      r_rd_ptr   <= w_rd_ptr_next;
      r_wr_ptr   <= w_wr_ptr_next;
      r_fa       <= w_fa_next;
      r_mem_addr <= w_mem_addr_next;
    end
  end

  // Queue storage; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_addr[w_wr_idx] <= r_mem_addr;
      r_q_data[w_wr_idx] <= mem_data;
    end
  end

endmodule

// File: tb/tb_insn_fetch.sv
// Self-checking bench for insn_fetch: directed scenarios with literal
// expectations plus a long randomized run, all compared every cycle against
// a queue-based behavioural model of the fetch unit.

module tb_insn_fetch;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RA    = 32'h0000_0100;
  localparam logic [31:0] KEY   = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] core_addr = RA;
  logic [31:0] core_data;
  logic        core_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_data = 32'd0;

  insn_fetch #(.DEPTH(DEPTH), .RESET_ADDR(RA)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .core_addr  (core_addr),
    .core_data  (core_data),
    .core_ready (core_ready),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Behavioural model: the queue as SV queues, plus fetch address and port mode.
  logic [31:0] m_q_addr[$];
  logic [31:0] m_q_data[$];
  logic [31:0] m_fa;
  int          m_mode;       // 0 no request, 1 live request, 2 stale request
  logic [31:0] m_req_addr;

  // Stimulus state.
  logic [31:0] core_drv;
  int          lat_mode;     // fixed memory latency, or -1 for random 0..4
  int          lat_cur;
  int          mem_wait;
  bit          stray;
  bit          last_hit;
  bit          prev_pending;
  logic [31:0] prev_maddr;

  // Observations of the last cycle, for literal checks.
  logic        obs_req;
  logic        obs_ready;
  logic [31:0] obs_data;
  logic [31:0] obs_maddr;
  logic [31:0] acked [8];
  int          n_acked;
  bit          seen_zero;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  function automatic int pick_lat();
    if (lat_mode < 0) return $urandom_range(0, 4);
    return lat_mode;
  endfunction

  task automatic model_reset();
    m_q_addr.delete();
    m_q_data.delete();
    m_fa       = RA;
    m_mode     = 0;
    m_req_addr = RA;
  endtask

  // Called at a negedge: asserts reset, checks outputs before any clock edge,
  // then releases reset at a later negedge.
  task automatic do_reset(input logic [31:0] first_core);
    reset_n = 1'b0;
    mem_ack = 1'b0;
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, RA);
    chk("rst_core_ready", {31'd0, core_ready}, 32'd0);
    chk("rst_core_data", core_data, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    cyc          = 0;
    mem_wait     = 0;
    lat_cur      = pick_lat();
    prev_pending = 1'b0;
    last_hit     = 1'b0;
    core_drv     = first_core;
    n_acked      = 0;
  endtask

  // One clock cycle: drive inputs, compare with the model, advance the model.
  task automatic cycle();
    logic [31:0] e;
    bit          nonempty, hit, pop, redir, ack;
    int          nb, outst;
    logic [31:0] exp_data;

    mem_ack  = 1'b0;
    mem_data = $urandom;
    if (mem_req) begin
      if (mem_wait >= lat_cur) begin
        mem_ack  = 1'b1;
        mem_data = mem_addr ^ KEY;
      end
    end else if (stray && $urandom_range(0, 3) == 0) begin
      mem_ack = 1'b1;
    end
    core_addr = core_drv;
    #1;

    nonempty = (m_q_addr.size() != 0);
    e        = m_fa;
    exp_data = 32'd0;
    if (nonempty) begin
      e        = m_q_addr[0];
      exp_data = m_q_data[0];
    end
    hit   = nonempty && (core_addr == e);
    pop   = nonempty && (core_addr == e + 32'd1);
    redir = (core_addr != e) && !pop;
    ack   = mem_ack && (m_mode != 0);

    chk("core_ready", {31'd0, core_ready}, {31'd0, hit});
    chk("mem_req", {31'd0, mem_req}, {31'd0, (m_mode != 0)});
    if (m_mode != 0) chk("mem_addr", mem_addr, m_req_addr);
    if (hit || !nonempty) chk("core_data", core_data, exp_data);
    if (prev_pending && mem_req) chk("mem_addr_hold", mem_addr, prev_maddr);

    obs_req   = mem_req;
    obs_ready = core_ready;
    obs_data  = core_data;
    obs_maddr = mem_addr;
    if (mem_req && mem_ack && n_acked < 8) begin
      acked[n_acked] = mem_addr;
      n_acked++;
    end
    if (core_ready && core_addr == 32'd0) seen_zero = 1'b1;
    prev_pending = mem_req && !mem_ack;
    prev_maddr   = mem_addr;

    if (mem_req) begin
      if (mem_ack) begin
        mem_wait = 0;
        lat_cur  = pick_lat();
      end else begin
        mem_wait++;
      end
    end else begin
      mem_wait = 0;
    end

    nb    = m_q_addr.size();
    outst = (m_mode != 0) ? 1 : 0;
    if (redir) begin
      m_q_addr.delete();
      m_q_data.delete();
      m_fa = core_addr;
    end else begin
      if (pop) begin
        void'(m_q_addr.pop_front());
        void'(m_q_data.pop_front());
      end
      if (m_mode == 1 && ack) begin
        m_q_addr.push_back(m_req_addr);
        m_q_data.push_back(mem_data);
        m_fa = m_fa + 32'd1;
      end
    end
    case (m_mode)
      0: if (redir || (nb + outst) < DEPTH) begin
           m_mode = 1;
           m_req_addr = m_fa;
         end
      1: if (ack) begin
           if (m_q_addr.size() < DEPTH) m_req_addr = m_fa;
           else m_mode = 0;
         end else if (redir) begin
           m_mode = 2;
         end
      default: if (ack) begin
           m_mode = 1;
           m_req_addr = m_fa;
         end
    endcase

    last_hit = hit;
    cyc++;
    @(negedge clk);
  endtask

  function automatic logic [31:0] jump_target();
    case ($urandom_range(0, 4))
      0: return core_drv + 32'd2;
      1: return core_drv - 32'd1;
      2: return 32'hFFFF_FFFE;
      3: return core_drv + 32'd1;
      default: return $urandom_range(0, 1023);
    endcase
  endfunction

  task automatic run(input int n, input int step_pct, input int jump_pct);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 99) < jump_pct) core_drv = jump_target();
      else if (last_hit && $urandom_range(0, 99) < step_pct) core_drv = core_drv + 32'd1;
      cycle();
    end
  endtask

  int nreq;
  logic [31:0] req_seen;

  initial begin
    lat_mode = 0;
    stray    = 1'b0;
    seen_zero = 1'b0;
    #2;
    @(negedge clk);

    // Zero-wait memory, core parked on the reset vector.
    do_reset(RA);
    cycle(); chk("z_c0_req", {31'd0, obs_req}, 32'd0);
    cycle(); chk("z_c1_req", {31'd0, obs_req}, 32'd1);
             chk("z_c1_addr", obs_maddr, RA);
    cycle(); chk("z_c2_ready", {31'd0, obs_ready}, 32'd1);
             chk("z_c2_data", obs_data, RA ^ KEY);
             chk("z_c2_addr", obs_maddr, RA + 32'd1);
    cycle(); chk("z_c3_addr", obs_maddr, RA + 32'd2);
    cycle(); chk("z_c4_addr", obs_maddr, RA + 32'd3);
    cycle();
    cycle(); chk("z_full_req", {31'd0, obs_req}, 32'd0);
    core_drv = RA + 32'd1;
    cycle(); chk("z_pop_ready", {31'd0, obs_ready}, 32'd0);
    cycle(); chk("z_next_data", obs_data, (RA + 32'd1) ^ KEY);
    nreq = 0;
    req_seen = 32'd0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (obs_req) begin
        nreq++;
        req_seen = obs_maddr;
      end
    end
    chk("z_one_refill", nreq, 32'd1);
    chk("z_refill_addr", req_seen, RA + 32'd4);

    // Three-cycle latency, core consuming in order.
    lat_mode = 3;
    do_reset(RA);
    run(80, 100, 0);

    // Redirect while a request is outstanding: stale data must be drained.
    lat_mode = 5;
    do_reset(32'h103);
    cycle(); // c0
    cycle(); chk("d_c1_addr", obs_maddr, 32'h103);
    core_drv = 32'h200;
    nreq = 0;
    for (int i = 2; i <= 12; i++) begin
      cycle();
      if (obs_ready) nreq++;
      if (i == 6) chk("d_c6_hold", obs_maddr, 32'h103);
      if (i == 7) chk("d_c7_addr", obs_maddr, 32'h200);
    end
    chk("d_no_early_ready", nreq, 32'd0);
    cycle(); chk("d_c13_ready", {31'd0, obs_ready}, 32'd1);
             chk("d_c13_data", obs_data, 32'h200 ^ KEY);

    // Address wrap-around.
    lat_mode = 0;
    seen_zero = 1'b0;
    do_reset(32'hFFFF_FFFE);
    run(30, 100, 0);
    chk("w_fetch0", acked[0], 32'hFFFF_FFFE);
    chk("w_fetch1", acked[1], 32'hFFFF_FFFF);
    chk("w_fetch2", acked[2], 32'h0000_0000);
    chk("w_fetch3", acked[3], 32'h0000_0001);
    chk("w_zero_ready", {31'd0, seen_zero}, 32'd1);

    // Redirect coincident with ack, then reset in the middle of a request.
    lat_mode = 2;
    do_reset(RA);
    cycle(); cycle(); cycle();
    core_drv = 32'h300;
    cycle(); chk("c_c3_addr", obs_maddr, RA);
    cycle(); chk("c_c4_addr", obs_maddr, 32'h300);
             chk("c_c4_req", {31'd0, obs_req}, 32'd1);
    cycle(); chk("c_c5_data", obs_data, 32'd0);
    cycle();
    cycle(); chk("c_c7_ready", {31'd0, obs_ready}, 32'd1);
             chk("c_c7_data", obs_data, 32'h300 ^ KEY);
    chk("ar_req_before", {31'd0, mem_req}, 32'd1);
    do_reset(RA);

    // Randomized traffic with stray acks and occasional resets.
    lat_mode = -1;
    stray    = 1'b1;
    for (int blk = 0; blk < 6; blk++) begin
      run(500, 70, 3);
      do_reset(($urandom_range(0, 1) == 0) ? RA : 32'hFFFF_FFFD);
    end
    run(100, 70, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
